cache_ctrl: RTL and testbench

//  Blocking, one-outstanding-request controller for one set-associative cache bank. Sequences the line-wide data RAM.

---
 rtl/cache_if.sv | 74 +++++++
 rtl/cache_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_if.sv
// ---------------------------------------------------------------------------
// cache_if: bundle of every signal between the cache controller and its
// neighbours. Three groups share it:
//   CPU request port  : req_* in, addr_ok / data_ok / rdata out
//   Memory-side bus   : rd_req/rd_addr/rd_rdy, ret_*, wr_req/wr_addr/wr_data/wr_rdy
//   Data RAM port     : ram_we/ram_replace/ram_index/ram_way/ram_din out, ram_dout in
// Modports:
//   slave  - the cache controller
//   master - whatever surrounds the controller (LSU, bus bridge, data RAM)
// ---------------------------------------------------------------------------
interface cache_if #(
    parameter int H = 256,
    parameter int N = 2,
    parameter int W = 4
);
    localparam int LOG_H = $clog2(H);
    localparam int LOG_N = $clog2(N);
    localparam int LOG_W = $clog2(W);
    localparam int TAG_W = 32 - LOG_H - LOG_W - 2;

    // CPU request port
    logic               req_valid;
    logic               req_op;
    logic [LOG_H-1:0]   req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [LOG_W-1:0]   req_offset;
    logic [3:0]         req_wstrb;
    logic [31:0]        req_wdata;
    logic               addr_ok;
    logic               data_ok;
    logic [31:0]        rdata;

    // Memory-side bus
    logic               rd_req;
    logic [31:0]        rd_addr;
    logic               rd_rdy;
    logic               ret_valid;
    logic               ret_last;
    logic [31:0]        ret_data;
    logic               wr_req;
    logic [31:0]        wr_addr;
    logic [W*32-1:0]    wr_data;
    logic               wr_rdy;

    // Data RAM port
    logic [W-1:0]       ram_we;
    logic               ram_replace;
    logic [LOG_H-1:0]   ram_index;
    logic [LOG_N-1:0]   ram_way;
    logic [W*32-1:0]    ram_din;
    logic [W*32-1:0]    ram_dout;

    modport slave (
        input  req_valid, req_op, req_index, req_tag, req_offset, req_wstrb, req_wdata,
        output addr_ok, data_ok, rdata,
        output rd_req, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output wr_req, wr_addr, wr_data,
        input  wr_rdy,
        output ram_we, ram_replace, ram_index, ram_way, ram_din,
        input  ram_dout
    );

    modport master (
        output req_valid, req_op, req_index, req_tag, req_offset, req_wstrb, req_wdata,
        input  addr_ok, data_ok, rdata,
        input  rd_req, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  wr_req, wr_addr, wr_data,
        output wr_rdy,
        input  ram_we, ram_replace, ram_index, ram_way, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl: blocking, one-outstanding-request controller for one
// set-associative cache bank. Tag/valid/dirty live in registers here; line
// data lives in an external RAM whose read port is combinational from
// ram_index/ram_way.
//
// Ports:
//   clk    - clock, all state on posedge
//   reset  - synchronous, active-high; aborts any request in flight
//   bus    - cache_if.slave: CPU request port, memory-side line bus
//            (refill + writeback) and data RAM control
//
// Flow: IDLE accepts a request -> LOOKUP. Hits complete in LOOKUP. Misses
// pick a victim, write it back if dirty (WB), request the line (RREQ),
// collect beats (REFILL) and install the line in one full-line write (FILL).
// ---------------------------------------------------------------------------
module cache_ctrl #(
    parameter int H = 256,
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic    clk,
    input  logic    reset,
    cache_if.slave  bus
);
    localparam int LOG_H = $clog2(H);
    localparam int LOG_N = $clog2(N);
    localparam int LOG_W = $clog2(W);
    localparam int TAG_W = 32 - LOG_H - LOG_W - 2;
    localparam int OFS_W = LOG_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_RREQ,
        S_REFILL,
        S_FILL
    } state_t;

    state_t             r_state;

    // Latched request
    logic               r_op;
    logic [LOG_H-1:0]   r_idx;
    logic [TAG_W-1:0]   r_tag_q;
    logic [LOG_W-1:0]   r_off;
    logic [3:0]         r_wstrb;
    logic [31:0]        r_wdata;
    logic [LOG_N-1:0]   r_victim;

    // Refill line buffer and beat counter
    logic [LOG_W-1:0]   r_cnt;
    logic [31:0]        r_line [W];

    // Replacement LFSR
    logic [7:0]         r_lfsr;

    // Per-set bookkeeping
    logic [TAG_W-1:0]   r_tags  [H][N];
    logic [N-1:0]       r_valid [H];
    logic [N-1:0]       r_dirty [H];

    // Lookup results
    logic               w_hit;
    logic [LOG_N-1:0]   w_hit_way;
    logic               w_has_inv;
    logic [LOG_N-1:0]   w_inv_way;
    logic [LOG_N-1:0]   w_victim;
    logic [31:0]        w_ram_word;
    logic [W*32-1:0]    w_fill_line;

    // Store byte-merge: bytes with strb set come from new_w, others keep old_w.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // Ways are scanned high-to-low so the lowest matching / invalid way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = N - 1; w >= 0; w--) begin
            if (r_valid[r_idx][w] && (r_tags[r_idx][w] == r_tag_q)) begin
                w_hit     = 1'b1;
                w_hit_way = LOG_N'(w);
            end
            if (!r_valid[r_idx][w]) begin
                w_has_inv = 1'b1;
                w_inv_way = LOG_N'(w);
            end
        end
        w_victim = w_has_inv ? w_inv_way : r_lfsr[LOG_N-1:0];
    end

    assign w_ram_word = bus.ram_dout[int'(r_off)*32 +: 32];

    // Line written at FILL: collected beats, with the store merged in for a
    // store miss. The pre-merge word is what a load returns.
    always_comb begin
        for (int k = 0; k < W; k++) begin
            w_fill_line[32*k +: 32] = r_line[k];
        end
        if (r_op) begin
            w_fill_line[int'(r_off)*32 +: 32] = byte_merge(r_line[r_off], r_wdata, r_wstrb);
        end
    end

    // Output decode. Everything except addr_ok is a function of registered
    // state; LOOKUP additionally depends on the combinational RAM read.
    always_comb begin
        bus.addr_ok     = (r_state == S_IDLE) && bus.req_valid && !reset;
        bus.data_ok     = 1'b0;
        bus.rdata       = '0;
        bus.rd_req      = 1'b0;
        bus.wr_req      = 1'b0;
        bus.ram_we      = '0;
        bus.ram_replace = 1'b0;
        bus.ram_index   = r_idx;
        bus.ram_way     = r_victim;
        bus.ram_din     = bus.ram_dout;
        bus.rd_addr     = {r_tag_q, r_idx, {OFS_W{1'b0}}};
        bus.wr_addr     = {r_tags[r_idx][r_victim], r_idx, {OFS_W{1'b0}}};
        bus.wr_data     = bus.ram_dout;

        case (r_state)
            S_LOOKUP: begin
                bus.ram_way = w_hit_way;
                if (w_hit) begin
                    bus.data_ok = 1'b1;
                    if (!r_op) begin
                        bus.rdata = w_ram_word;
                    end else begin
                        bus.ram_we = W'(1) << r_off;
                        bus.ram_din[int'(r_off)*32 +: 32] = byte_merge(w_ram_word, r_wdata, r_wstrb);
                    end
                end
            end
            S_WB: begin
                bus.wr_req = 1'b1;
            end
            S_RREQ: begin
                bus.rd_req = 1'b1;
            end
            S_FILL: begin
                bus.ram_replace = 1'b1;
                bus.ram_din     = w_fill_line;
                bus.data_ok     = 1'b1;
                if (!r_op) bus.rdata = r_line[r_off];
            end
            default: ;
        endcase
    end

    // Controller state machine. Request/line-buffer registers are data and
    // are not cleared by reset; the unfilled tail of a short refill is zeroed
    // when the refill starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            for (int i = 0; i < H; i++) begin
                r_valid[i] <= '0;
                r_dirty[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_idx   <= bus.req_index;
                        r_tag_q <= bus.req_tag;
                        r_off   <= bus.req_offset;
                        r_wstrb <= bus.req_wstrb;
                        r_wdata <= bus.req_wdata;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_op) r_dirty[r_idx][w_hit_way] <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_victim <= w_victim;
                        if (r_valid[r_idx][w_victim] && r_dirty[r_idx][w_victim]) begin
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_RREQ;
                        end
                    end
                end
                S_WB: begin
                    if (bus.wr_rdy) r_state <= S_RREQ;
                end
                S_RREQ: begin
                    if (bus.rd_rdy) begin
                        r_cnt   <= '0;
                        for (int k = 0; k < W; k++) begin
                            r_line[k] <= '0;
                        end
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.ret_valid) begin
                        r_line[r_cnt] <= bus.ret_data;
                        r_cnt         <= r_cnt + 1'b1;
                        if (bus.ret_last) r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_valid[r_idx][r_victim] <= 1'b1;
                    r_dirty[r_idx][r_victim] <= r_op;
                    r_state                  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag array: written only when a line is installed.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == S_FILL)) begin
            r_tags[r_idx][r_victim] <= r_tag_q;
        end
    end

    // 8-bit Fibonacci LFSR, taps 8,6,5,4; free-running out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
    localparam int H     = 256;
    localparam int N     = 2;
    localparam int W     = 4;
    localparam int LOG_N = 1;
    localparam int TAG_W = 20;
    localparam int LW    = W * 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_if #(.H(H), .N(N), .W(W)) bus ();

    cache_ctrl #(.H(H), .N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Data RAM: combinational read, synchronous write.
    logic [LW-1:0] ram [H][N];
    assign bus.ram_dout = ram[bus.ram_index][bus.ram_way];
    always @(posedge clk) begin
        if (bus.ram_replace) begin
            ram[bus.ram_index][bus.ram_way] <= bus.ram_din;
        end else begin
            for (int k = 0; k < W; k++) begin
                if (bus.ram_we[k]) ram[bus.ram_index][bus.ram_way][32*k +: 32] <= bus.ram_din[32*k +: 32];
            end
        end
    end

    // Replacement LFSR value as the rule defines it.
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= 8'h01;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Reference cache contents and backing memory.
    logic [TAG_W-1:0] m_tag   [H][N];
    bit               m_valid [H][N];
    bit               m_dirty [H][N];
    logic [LW-1:0]    m_data  [H][N];
    logic [LW-1:0]    mem     [bit [31:0]];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] laddr(input logic [TAG_W-1:0] t, input logic [7:0] i);
        return {t, i, 4'b0000};
    endfunction

    function automatic logic [LW-1:0] dflt_line(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < W; k++) l[32*k +: 32] = a ^ (32'h9E3779B9 * 32'(k + 1));
        return l;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < H; i++)
            for (int w = 0; w < N; w++) begin
                m_valid[i][w] = 1'b0;
                m_dirty[i][w] = 1'b0;
            end
    endtask

    // Structural invariants, every cycle out of reset.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            n_cmp++;
            assert (!(bus.rd_req && bus.wr_req)) else begin
                n_err++;
                $error("FAIL excl_req: rd_req=%b wr_req=%b, required not both", bus.rd_req, bus.wr_req);
            end
            n_cmp++;
            assert (!((|bus.ram_we) && bus.ram_replace)) else begin
                n_err++;
                $error("FAIL excl_ram: ram_we=%b ram_replace=%b, required not both", bus.ram_we, bus.ram_replace);
            end
        end
    end

    // One CPU access, driven and checked cycle by cycle against the model.
    // abort_beats >= 0 asserts reset after that many refill beats.
    task automatic access(input bit op, input logic [7:0] idx, input logic [TAG_W-1:0] tag,
                          input logic [1:0] off, input logic [3:0] strb, input logic [31:0] wd,
                          input int wb_dly, input int rd_dly, input int nbeats, input int abort_beats);
        bit            hit;
        int            hw;
        int            v;
        int            gap;
        logic [31:0]   a;
        logic [LW-1:0] line;
        logic [LW-1:0] newline;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_index  = idx;
        bus.req_tag    = tag;
        bus.req_offset = off;
        bus.req_wstrb  = strb;
        bus.req_wdata  = wd;
        #1;
        chk("addr_ok", LW'(bus.addr_ok), LW'(1));

        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_op     = 1'($urandom);
        bus.req_index  = 8'($urandom);
        bus.req_tag    = TAG_W'($urandom);
        bus.req_offset = 2'($urandom);
        bus.req_wstrb  = 4'($urandom);
        bus.req_wdata  = $urandom;
        #1;
        chk("lookup_addr_ok", LW'(bus.addr_ok), LW'(0));

        hit = 1'b0;
        hw  = 0;
        for (int w = 0; w < N; w++) begin
            if (!hit && m_valid[idx][w] && m_tag[idx][w] == tag) begin
                hit = 1'b1;
                hw  = w;
            end
        end

        if (hit) begin
            chk("hit_data_ok", LW'(bus.data_ok), LW'(1));
            chk("hit_no_rd_req", LW'(bus.rd_req), LW'(0));
            if (!op) chk("hit_rdata", LW'(bus.rdata), LW'(m_data[idx][hw][int'(off)*32 +: 32]));
            else begin
                m_data[idx][hw][int'(off)*32 +: 32] = merge(m_data[idx][hw][int'(off)*32 +: 32], wd, strb);
                m_dirty[idx][hw] = 1'b1;
            end
            @(negedge clk);
            #1;
            chk("hit_done", LW'(bus.data_ok), LW'(0));
            chk("hit_ram_line", ram[idx][hw], m_data[idx][hw]);
            return;
        end

        chk("miss_data_ok", LW'(bus.data_ok), LW'(0));
        v = -1;
        for (int w = N - 1; w >= 0; w--) if (!m_valid[idx][w]) v = w;
        if (v < 0) v = int'(m_lfsr[LOG_N-1:0]);
        a = laddr(tag, idx);

        if (m_valid[idx][v] && m_dirty[idx][v]) begin
            for (int c = 0; c <= wb_dly; c++) begin
                @(negedge clk);
                bus.wr_rdy = (c == wb_dly);
                #1;
                chk("wb_req", LW'(bus.wr_req), LW'(1));
                chk("wb_no_rd_req", LW'(bus.rd_req), LW'(0));
                chk("wb_addr", LW'(bus.wr_addr), LW'(laddr(m_tag[idx][v], idx)));
                chk("wb_data", bus.wr_data, m_data[idx][v]);
            end
            mem[laddr(m_tag[idx][v], idx)] = m_data[idx][v];
        end

        for (int c = 0; c <= rd_dly; c++) begin
            @(negedge clk);
            bus.wr_rdy = 1'b0;
            bus.rd_rdy = (c == rd_dly);
            #1;
            chk("rd_req", LW'(bus.rd_req), LW'(1));
            chk("rd_no_wr_req", LW'(bus.wr_req), LW'(0));
            chk("rd_addr", LW'(bus.rd_addr), LW'(a));
        end

        line    = mem.exists(a) ? mem[a] : dflt_line(a);
        newline = '0;
        for (int k = 0; k < nbeats; k++) begin
            if (k == abort_beats) begin
                @(negedge clk);
                bus.rd_rdy    = 1'b0;
                bus.ret_valid = 1'b0;
                bus.ret_last  = 1'b0;
                reset         = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                #1;
                chk("rst_addr_ok", LW'(bus.addr_ok), LW'(0));
                chk("rst_data_ok", LW'(bus.data_ok), LW'(0));
                chk("rst_rd_req", LW'(bus.rd_req), LW'(0));
                chk("rst_wr_req", LW'(bus.wr_req), LW'(0));
                chk("rst_ram_we", LW'(bus.ram_we), LW'(0));
                chk("rst_ram_replace", LW'(bus.ram_replace), LW'(0));
                model_reset();
                return;
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.rd_rdy    = 1'b0;
                bus.ret_valid = 1'b0;
                bus.ret_last  = 1'b0;
                #1;
                chk("refill_wait_data_ok", LW'(bus.data_ok), LW'(0));
            end
            @(negedge clk);
            bus.rd_rdy    = 1'b0;
            bus.ret_valid = 1'b1;
            bus.ret_data  = line[32*k +: 32];
            bus.ret_last  = (k == nbeats - 1);
            #1;
            chk("refill_no_rd_req", LW'(bus.rd_req), LW'(0));
            chk("refill_data_ok", LW'(bus.data_ok), LW'(0));
            newline[32*k +: 32] = line[32*k +: 32];
        end

        @(negedge clk);
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        #1;
        chk("fill_data_ok", LW'(bus.data_ok), LW'(1));
        chk("fill_replace", LW'(bus.ram_replace), LW'(1));
        if (!op) chk("fill_rdata", LW'(bus.rdata), LW'(newline[int'(off)*32 +: 32]));
        else newline[int'(off)*32 +: 32] = merge(newline[int'(off)*32 +: 32], wd, strb);
        m_tag[idx][v]   = tag;
        m_valid[idx][v] = 1'b1;
        m_dirty[idx][v] = op;
        m_data[idx][v]  = newline;

        @(negedge clk);
        #1;
        chk("fill_done", LW'(bus.data_ok), LW'(0));
        chk("fill_ram_line", ram[idx][v], newline);
    endtask

    logic [TAG_W-1:0] tag_pool [4];
    logic [7:0]       idx_pool [3];

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 1'b0;
        bus.req_index  = '0;
        bus.req_tag    = '0;
        bus.req_offset = '0;
        bus.req_wstrb  = '0;
        bus.req_wdata  = '0;
        bus.rd_rdy     = 1'b0;
        bus.wr_rdy     = 1'b0;
        bus.ret_valid  = 1'b0;
        bus.ret_last   = 1'b0;
        bus.ret_data   = '0;
        reset          = 1'b1;
        model_reset();
        tag_pool = '{20'h00010, 20'h00020, 20'h00030, 20'h00040};
        idx_pool = '{8'd5, 8'd6, 8'd9};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_addr_ok", LW'(bus.addr_ok), LW'(0));
        chk("reset_data_ok", LW'(bus.data_ok), LW'(0));
        chk("reset_rd_req", LW'(bus.rd_req), LW'(0));
        chk("reset_wr_req", LW'(bus.wr_req), LW'(0));
        chk("reset_ram_we", LW'(bus.ram_we), LW'(0));
        chk("reset_ram_replace", LW'(bus.ram_replace), LW'(0));

        // Cold load: beats 0xA0..0xA3, word 2 returned
        mem[laddr(20'h12345, 8'd5)] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        access(1'b0, 8'd5, 20'h12345, 2'd2, 4'h0, 32'h0, 0, 1, W, -1);

        // Repeat load, same line, word 1: hit in LOOKUP
        access(1'b0, 8'd5, 20'h12345, 2'd1, 4'h0, 32'h0, 0, 0, W, -1);

        // Store hit, low half-word into word 0
        access(1'b1, 8'd5, 20'h12345, 2'd0, 4'b0011, 32'hFFFF_BEEF, 0, 0, W, -1);
        chk("store_hit_word", LW'(ram[5][0][31:0]), LW'(32'h0000_BEEF));

        // Dirty store miss into the second way, then a third tag forces a
        // dirty writeback with wr_rdy held low for 10 cycles
        access(1'b1, 8'd5, 20'h00777, 2'd3, 4'b1111, 32'h1234_5678, 0, 2, W, -1);
        access(1'b0, 8'd5, 20'h00999, 2'd0, 4'h0, 32'h0, 10, 1, W, -1);

        // Short refill: last on beat 2, words 2..3 stay zero
        access(1'b0, 8'd9, 20'h00042, 2'd3, 4'h0, 32'h0, 0, 0, 2, -1);
        access(1'b0, 8'd9, 20'h00042, 2'd1, 4'h0, 32'h0, 0, 0, W, -1);

        // Reset mid-refill, then the previously cached line must miss
        access(1'b0, 8'd7, 20'h0ABCD, 2'd0, 4'h0, 32'h0, 0, 0, W, 2);
        access(1'b0, 8'd5, 20'h12345, 2'd0, 4'h0, 32'h0, 0, 0, W, -1);

        // Randomized traffic over a few sets and tags
        for (int t = 0; t < 80; t++) begin
            access(1'($urandom), idx_pool[$urandom_range(0, 2)], tag_pool[$urandom_range(0, 3)],
                   2'($urandom), 4'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), W, -1);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
